// File: rtl/accel_pkg.sv
// Shared constants and types for the ADXL345 SPI reader.
// Register map, command flags, frame lengths and FSM encodings.
package accel_pkg;

  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

  localparam logic [7:0] RD_FLAG = 8'h80;
  localparam logic [7:0] MB_FLAG = 8'h40;

  localparam logic [5:0] LEN_CFG  = 6'd16;
  localparam logic [5:0] LEN_READ = 6'd56;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_FMT,
    S_CFG_PWR,
    S_WAIT_TICK,
    S_READ,
    S_UPDATE
  } state_t;

  typedef enum logic [2:0] {
    E_IDLE,
    E_LEAD,
    E_LOW,
    E_HIGH,
    E_GAP
  } phase_t;

  // Frames are shifted out MSB-first from bit 55.
  function automatic logic [55:0] cfg_word(
    input logic [7:0] addr,
    input logic [7:0] val
  );
    return {addr, val, 40'h0};
  endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// SPI mode-3 frame engine: cs_n/sclk/mosi sequencing and miso capture.
// Frames up to 56 bits; done pulses at the end of the cs_n-high gap.
module spi_frame_engine
  import accel_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  len,
  input  logic [55:0] tx,
  input  logic        miso,
  output logic [47:0] rx,
  output logic        done,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAPL = CW'(2 * CLK_DIV - 1);

  phase_t phase;
  phase_t phase_nx;

  logic [CW-1:0] cnt;
  logic [5:0]    bits;
  logic [5:0]    nbits;
  logic [55:0]   sh;
  logic          half_end;
  logic          gap_end;
  logic          launch;
  logic          fall;
  logic          rise;
  logic          last;

  assign half_end = cnt == HALF;
  assign gap_end  = (phase == E_GAP) && (cnt == GAPL);
  assign done     = gap_end;
  assign launch   = start && ((phase == E_IDLE) || gap_end);
  assign last     = (phase == E_HIGH) && half_end && (bits == nbits);
  assign rise     = (phase == E_LOW) && half_end;
  assign fall     = half_end &&
                    ((phase == E_LEAD) ||
                     ((phase == E_HIGH) && (bits != nbits)));

  always_comb begin
    phase_nx = phase;
    unique case (phase)
      E_IDLE: if (launch) phase_nx = E_LEAD;
      E_LEAD: if (half_end) phase_nx = E_LOW;
      E_LOW:  if (half_end) phase_nx = E_HIGH;
      E_HIGH: begin
        if (half_end)
          phase_nx = (bits == nbits) ? E_GAP : E_LOW;
      end
      E_GAP: begin
        if (gap_end)
          phase_nx = launch ? E_LEAD : E_IDLE;
      end
      default: phase_nx = E_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= E_IDLE;
      cnt   <= '0;
      bits  <= '0;
      nbits <= '0;
      sh    <= '0;
      rx    <= '0;
      sclk  <= 1'b1;
      cs_n  <= 1'b1;
      mosi  <= 1'b0;
    end else begin
      phase <= phase_nx;
      if ((phase_nx != phase) || (phase == E_IDLE))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (launch) begin
        cs_n  <= 1'b0;
        sh    <= tx;
        nbits <= len;
        bits  <= '0;
      end
      if (fall) begin
        sclk <= 1'b0;
        mosi <= sh[55];
        sh   <= {sh[54:0], 1'b0};
      end
      if (rise) begin
        sclk <= 1'b1;
        rx   <= {rx[46:0], miso};
        bits <= bits + 1'b1;
      end
      if (last)
        cs_n <= 1'b1;
    end
  end

endmodule

// File: rtl/accel_spi_reader.sv
// ADXL345 reader: configures the sensor, then burst-reads X/Y/Z on a
// free-running sample timebase and presents them with a valid strobe.
module accel_spi_reader
  import accel_pkg::*;
#(
  parameter int          CLK_DIV         = 25,
  parameter int          SAMPLE_PERIOD   = 500000,
  parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
  parameter logic [7:0]  POWER_CTL_VAL   = 8'h08
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        miso,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic [15:0] z_out,
  output logic        sample_valid,
  output logic        init_done,
  output logic        busy
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);

  state_t state;
  state_t state_nx;

  logic [TW-1:0] tcnt;
  logic          tick;
  logic          pending;
  logic          take;
  logic          start;
  logic          done;
  logic [5:0]    len;
  logic [55:0]   tx;
  logic [47:0]   rx;

  assign tick = tcnt == TICK_LAST;
  assign take = (state == S_WAIT_TICK) && pending;
  assign busy = ~cs_n;

  // At most one read request is queued; surplus ticks are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt    <= '0;
      pending <= 1'b0;
    end else begin
      tcnt    <= tick ? '0 : tcnt + 1'b1;
      pending <= tick | (pending & ~take);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:      state_nx = S_CFG_FMT;
      S_CFG_FMT:   if (done) state_nx = S_CFG_PWR;
      S_CFG_PWR:   if (done) state_nx = S_WAIT_TICK;
      S_WAIT_TICK: if (pending) state_nx = S_READ;
      S_READ:      if (done) state_nx = S_UPDATE;
      S_UPDATE:    state_nx = S_WAIT_TICK;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Frames launch on the transition into the state that owns them.
  always_comb begin
    start = 1'b0;
    len   = LEN_READ;
    tx    = {RD_FLAG | MB_FLAG | REG_DATAX0, 48'h0};
    unique case (1'b1)
      state == S_IDLE: begin
        start = 1'b1;
        len   = LEN_CFG;
        tx    = cfg_word(REG_DATA_FORMAT, DATA_FORMAT_VAL);
      end
      state == S_CFG_FMT: begin
        start = done;
        len   = LEN_CFG;
        tx    = cfg_word(REG_POWER_CTL, POWER_CTL_VAL);
      end
      state == S_WAIT_TICK: start = pending;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_out        <= '0;
      y_out        <= '0;
      z_out        <= '0;
      sample_valid <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      sample_valid <= state == S_UPDATE;
      if ((state == S_CFG_PWR) && done)
        init_done <= 1'b1;
      if (state == S_UPDATE) begin
        x_out <= {rx[39:32], rx[47:40]};
        y_out <= {rx[23:16], rx[31:24]};
        z_out <= {rx[7:0],   rx[15:8]};
      end
    end
  end

  spi_frame_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .len     (len),
    .tx      (tx),
    .miso    (miso),
    .rx      (rx),
    .done    (done),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi)
  );

endmodule
